// File: rtl/rps_pkg.sv
// Shared encodings for the stone/paper/scissors pipeline: round result codes,
// match winner codes and the scorer state encoding.
package rps_pkg;

    typedef enum logic [1:0] {
        RES_TIE     = 2'b00,
        RES_P1      = 2'b01,
        RES_P2      = 2'b10,
        RES_INVALID = 2'b11
    } result_e;

    // Also used for the streak holder: 00 means nobody.
    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10
    } winner_e;

    typedef enum logic {
        S_PLAY = 1'b0,
        S_DONE = 1'b1
    } scorer_state_e;

endpackage

// File: rtl/rps_streak_tracker.sv
// Tracks which player holds the current run of consecutive round wins and
// how long that run is. Ties break the run; invalid moves leave it alone.
module rps_streak_tracker
    import rps_pkg::*;
#(
    parameter int SCORE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               accept,
    input  logic [1:0]         code,
    output logic [1:0]         holder,
    output logic [SCORE_W-1:0] len
);

    winner_e            holder_q, holder_d;
    logic [SCORE_W-1:0] len_q, len_d;

    // Next streak from the accepted result; clear wins over any result.
    always_comb begin
        holder_d = holder_q;
        len_d    = len_q;
        if (clear) begin
            holder_d = WIN_NONE;
            len_d    = '0;
        end else if (accept) begin
            case (code)
                RES_P1: begin
                    if (holder_q == WIN_P1) begin
                        len_d = len_q + 1'b1;
                    end else begin
                        holder_d = WIN_P1;
                        len_d    = SCORE_W'(1);
                    end
                end
                RES_P2: begin
                    if (holder_q == WIN_P2) begin
                        len_d = len_q + 1'b1;
                    end else begin
                        holder_d = WIN_P2;
                        len_d    = SCORE_W'(1);
                    end
                end
                RES_TIE: begin
                    holder_d = WIN_NONE;
                    len_d    = '0;
                end
                default: begin
                    holder_d = holder_q;
                    len_d    = len_q;
                end
            endcase
        end
    end

    // Streak registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            holder_q <= WIN_NONE;
            len_q    <= '0;
        end else begin
            holder_q <= holder_d;
            len_q    <= len_d;
        end
    end

    assign holder = holder_q;
    assign len    = len_q;

endmodule

// File: rtl/rps_match_scorer.sv
// Match scorer: accepts one round result per valid/ready handshake, keeps the
// score, tie and invalid counts, and declares the match winner.
//
// Handshake: a result transfers on a rising edge where result_valid and
// result_ready are both high. result_ready is high only in PLAY while
// new_match is low; valid may be held without obligation when ready is low,
// and the code is only looked at in the transfer cycle.
module rps_match_scorer
    import rps_pkg::*;
#(
    parameter int WIN_TARGET = 3,
    parameter int MAX_ROUNDS = 9,
    parameter int SCORE_W    = 4,
    parameter int ROUND_W    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               result_valid,
    input  logic [1:0]         result_code,
    output logic               result_ready,
    input  logic               new_match,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [ROUND_W-1:0] round_count,
    output logic [ROUND_W-1:0] tie_count,
    output logic [ROUND_W-1:0] invalid_count,
    output logic [1:0]         streak_holder,
    output logic [SCORE_W-1:0] streak_len,
    output logic               match_over,
    output logic [1:0]         match_winner,
    output logic               match_done,
    output logic               dbg_state
);

    scorer_state_e      state_q, state_d;
    logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
    logic [ROUND_W-1:0] rounds_q, rounds_d, ties_q, ties_d, inv_q, inv_d;
    winner_e            winner_q, winner_d;
    logic               done_q, done_d;
    logic               accept;

    assign result_ready = (state_q == S_PLAY) && !new_match;
    assign accept       = result_valid && result_ready;

    // Next match state: apply the accepted result, then decide the match on
    // the post-update counts so the decision lands on the same edge.
    always_comb begin
        state_d  = state_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        rounds_d = rounds_q;
        ties_d   = ties_q;
        inv_d    = inv_q;
        winner_d = winner_q;
        done_d   = 1'b0;
        if (new_match) begin
            state_d  = S_PLAY;
            p1_d     = '0;
            p2_d     = '0;
            rounds_d = '0;
            ties_d   = '0;
            inv_d    = '0;
            winner_d = WIN_NONE;
        end else if (accept) begin
            case (result_code)
                RES_P1: begin
                    p1_d     = p1_q + 1'b1;
                    rounds_d = rounds_q + 1'b1;
                end
                RES_P2: begin
                    p2_d     = p2_q + 1'b1;
                    rounds_d = rounds_q + 1'b1;
                end
                RES_TIE: begin
                    ties_d   = ties_q + 1'b1;
                    rounds_d = rounds_q + 1'b1;
                end
                default: begin
                    if (inv_q != '1) begin
                        inv_d = inv_q + 1'b1;
                    end
                end
            endcase
            // Invalid results never advance the match, so they cannot end it.
            if (result_code != RES_INVALID) begin
                if (p1_d == SCORE_W'(WIN_TARGET)) begin
                    state_d  = S_DONE;
                    winner_d = WIN_P1;
                end else if (p2_d == SCORE_W'(WIN_TARGET)) begin
                    state_d  = S_DONE;
                    winner_d = WIN_P2;
                end else if (rounds_d == ROUND_W'(MAX_ROUNDS)) begin
                    state_d = S_DONE;
                    if (p1_d > p2_d) begin
                        winner_d = WIN_P1;
                    end else if (p2_d > p1_d) begin
                        winner_d = WIN_P2;
                    end else begin
                        winner_d = WIN_NONE;
                    end
                end
                done_d = (state_d == S_DONE);
            end
        end
    end

    // State and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_PLAY;
            p1_q     <= '0;
            p2_q     <= '0;
            rounds_q <= '0;
            ties_q   <= '0;
            inv_q    <= '0;
            winner_q <= WIN_NONE;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            rounds_q <= rounds_d;
            ties_q   <= ties_d;
            inv_q    <= inv_d;
            winner_q <= winner_d;
            done_q   <= done_d;
        end
    end

    rps_streak_tracker #(
        .SCORE_W(SCORE_W)
    ) u_streak (
        .clk   (clk),
        .reset (reset),
        .clear (new_match),
        .accept(accept),
        .code  (result_code),
        .holder(streak_holder),
        .len   (streak_len)
    );

    assign p1_score      = p1_q;
    assign p2_score      = p2_q;
    assign round_count   = rounds_q;
    assign tie_count     = ties_q;
    assign invalid_count = inv_q;
    assign match_over    = (state_q == S_DONE);
    assign match_winner  = winner_q;
    assign match_done    = done_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_rps_match_scorer.sv
// Bench for rps_match_scorer: directed match scenarios followed by random
// traffic, checked every cycle against a reference model of the match rules.
module tb_rps_match_scorer;
  import rps_pkg::*;

  localparam int WT = 3;
  localparam int MR = 9;
  localparam int SW = 4;
  localparam int RW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          result_valid;
  logic [1:0]    result_code;
  logic          result_ready;
  logic          new_match;
  logic [SW-1:0] p1_score, p2_score, streak_len;
  logic [RW-1:0] round_count, tie_count, invalid_count;
  logic [1:0]    streak_holder, match_winner;
  logic          match_over, match_done, dbg_state;

  rps_match_scorer #(
    .WIN_TARGET(WT), .MAX_ROUNDS(MR), .SCORE_W(SW), .ROUND_W(RW)
  ) dut (
    .clk(clk), .reset(reset),
    .result_valid(result_valid), .result_code(result_code),
    .result_ready(result_ready), .new_match(new_match),
    .p1_score(p1_score), .p2_score(p2_score),
    .round_count(round_count), .tie_count(tie_count),
    .invalid_count(invalid_count),
    .streak_holder(streak_holder), .streak_len(streak_len),
    .match_over(match_over), .match_winner(match_winner),
    .match_done(match_done), .dbg_state(dbg_state)
  );

  typedef struct packed {
    logic [SW-1:0] p1;
    logic [SW-1:0] p2;
    logic [RW-1:0] rounds;
    logic [RW-1:0] ties;
    logic [RW-1:0] inv;
    logic [1:0]    holder;
    logic [SW-1:0] len;
    logic          over;
    logic [1:0]    winner;
    logic          done;
    logic          st;
  } snap_t;
  localparam int SNAP_W = $bits(snap_t);

  logic [SNAP_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  int   m_p1, m_p2, m_inv;
  bit   m_over;
  int   m_win;
  int   hist[$];   // counted rounds in order: 0 tie, 1 P1, 2 P2

  function automatic snap_t model_snap(bit done);
    snap_t s;
    int hold, len, ties;
    hold = 0;
    len  = 0;
    ties = 0;
    foreach (hist[i]) if (hist[i] == 0) ties++;
    if (hist.size() > 0 && hist[hist.size()-1] != 0) begin
      hold = hist[hist.size()-1];
      for (int i = hist.size() - 1; i >= 0; i--) begin
        if (hist[i] == hold) len++;
        else break;
      end
    end
    s.p1     = SW'(m_p1);
    s.p2     = SW'(m_p2);
    s.rounds = RW'(hist.size());
    s.ties   = RW'(ties);
    s.inv    = RW'(m_inv);
    s.holder = 2'(hold);
    s.len    = SW'(len);
    s.over   = m_over;
    s.winner = 2'(m_win);
    s.done   = done;
    s.st     = m_over;
    return s;
  endfunction

  task automatic model_clear();
    m_p1 = 0; m_p2 = 0; m_inv = 0; m_over = 0; m_win = 0;
    hist.delete();
  endtask

  task automatic model_step(input bit v, input int c, input bit nm);
    bit done;
    done = 0;
    if (nm) begin
      model_clear();
    end else if (!m_over && v) begin
      if (c == 3) begin
        if (m_inv < (1 << RW) - 1) m_inv++;
      end else begin
        hist.push_back(c);
        if (c == 1) m_p1++;
        if (c == 2) m_p2++;
        if (m_p1 == WT) begin m_over = 1; m_win = 1; end
        else if (m_p2 == WT) begin m_over = 1; m_win = 2; end
        else if (hist.size() == MR) begin
          m_over = 1;
          m_win  = (m_p1 > m_p2) ? 1 : (m_p2 > m_p1) ? 2 : 0;
        end
        done = m_over;
      end
    end
    exp_q.push_back(model_snap(done));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit v, input logic [1:0] c, input bit nm);
    bit exp_ready;
    @(posedge clk);
    #3;
    reset        = 1'b0;
    result_valid = v;
    result_code  = c;
    new_match    = nm;
    exp_ready    = !m_over && !nm;
    model_step(v, int'(c), nm);
    #1;
    n_cmp++;
    if (result_ready !== exp_ready) begin
      n_bad++;
      $display("FAIL result_ready t=%0t got %b want %b", $time, result_ready, exp_ready);
    end
  endtask

  task automatic step_reset();
    @(posedge clk);
    #3;
    reset        = 1'b1;
    result_valid = 1'b0;
    result_code  = 2'b00;
    new_match    = 1'b0;
    model_clear();
    exp_q.push_back(model_snap(1'b0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    snap_t act, exp;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        act.p1 = p1_score;        act.p2 = p2_score;
        act.rounds = round_count; act.ties = tie_count;
        act.inv = invalid_count;  act.holder = streak_holder;
        act.len = streak_len;     act.over = match_over;
        act.winner = match_winner; act.done = match_done;
        act.st = dbg_state;
        n_cmp++;
        if (act !== exp) begin
          n_bad++;
          $display("FAIL outputs t=%0t got p1=%0d p2=%0d rnd=%0d tie=%0d inv=%0d hold=%0d len=%0d over=%b win=%0d done=%b st=%b want p1=%0d p2=%0d rnd=%0d tie=%0d inv=%0d hold=%0d len=%0d over=%b win=%0d done=%b st=%b",
                   $time, act.p1, act.p2, act.rounds, act.ties, act.inv, act.holder, act.len,
                   act.over, act.winner, act.done, act.st,
                   exp.p1, exp.p2, exp.rounds, exp.ties, exp.inv, exp.holder, exp.len,
                   exp.over, exp.winner, exp.done, exp.st);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int s_draw[9] = '{1, 2, 0, 1, 2, 0, 0, 0, 0};
    int s_p1r9[9] = '{1, 2, 0, 0, 2, 0, 0, 1, 1};
    int s_mix[4]  = '{1, 1, 0, 2};
    reset        = 1'b1;
    result_valid = 1'b0;
    result_code  = 2'b00;
    new_match    = 1'b0;
    model_clear();
    step_reset();
    step_reset();

    // P1 wins three straight rounds.
    for (int i = 0; i < 3; i++) step(1'b1, 2'b01, 1'b0);
    idle(2);
    step(1'b1, 2'b10, 1'b0);   // ignored while decided
    step(1'b0, 2'b00, 1'b1);

    // Nine rounds ending level: draw at the round limit.
    foreach (s_draw[i]) step(1'b1, 2'(s_draw[i]), 1'b0);
    idle(2);
    step(1'b0, 2'b00, 1'b1);

    // P1 reaches the target on the last allowed round.
    foreach (s_p1r9[i]) step(1'b1, 2'(s_p1r9[i]), 1'b0);
    idle(1);
    step(1'b0, 2'b00, 1'b1);

    // Invalid results saturate and do not advance the match.
    for (int i = 0; i < 16; i++) step(1'b1, 2'b11, 1'b0);
    step(1'b1, 2'b01, 1'b0);
    step(1'b0, 2'b00, 1'b1);

    // Streak broken by a tie, then a new holder.
    foreach (s_mix[i]) step(1'b1, 2'(s_mix[i]), 1'b0);
    // new_match collides with a result: result dropped.
    step(1'b1, 2'b01, 1'b1);
    step(1'b1, 2'b01, 1'b1);   // held high: stays cleared
    idle(1);

    // Reset while decided.
    for (int i = 0; i < 3; i++) step(1'b1, 2'b10, 1'b0);
    idle(1);
    step_reset();
    step_reset();
    idle(2);
    step(1'b1, 2'b01, 1'b0);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r < 2) step_reset();
      else step($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), $urandom_range(0, 99) < 4);
    end

    idle(2);
    @(posedge clk);
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
